// File: rtl/dcache_mem_stage.sv
// Memory-stage data cache: direct-mapped, one 32-bit word per line,
// write-through with no write allocate, in front of a variable-latency
// backing memory. Loads that hit return data in the same cycle; misses and
// all stores hold the pipeline (StallM) until the backing memory acks.
//
// Backing-memory handshake: the cache raises mem_req together with a stable
// mem_we/mem_addr/mem_wdata/mem_wstrb and keeps them unchanged until the
// cycle in which mem_ack is sampled high; that cycle completes the transfer
// and mem_req drops on the next cycle. mem_ack in any other cycle is ignored.
//
// o_dbg_state exposes the controller state (IDLE=0, FILL=1, WRITE=2, WDONE=3).
module dcache_mem_stage #(
    parameter int WIDTH    = 32,
    parameter int IDX_BITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic             a_typeM,
    input  logic [WIDTH-1:0] AddrM,
    input  logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             StallM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [1:0]       o_dbg_state
);

    localparam int LINES    = 1 << IDX_BITS;
    localparam int TAG_BITS = WIDTH - IDX_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_WDONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Line storage. Only the valid bits need reset; tag/data are don't-care
    // while their line is invalid.
    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [WIDTH-1:0]    r_data [LINES];

    // Transaction held while waiting on the backing memory (word address only).
    logic [WIDTH-3:0]    r_waddr;
    logic [WIDTH-1:0]    r_wdata;
    logic [3:0]          r_wstrb;

    // Lookup for the access currently presented by the pipeline.
    logic [IDX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0] w_tag;
    logic                w_hit;
    logic [WIDTH-1:0]    w_line;
    logic [WIDTH-1:0]    w_shifted;
    logic [7:0]          w_byte;

    // Lookup for the held transaction (used when a fill/store completes).
    logic [IDX_BITS-1:0] w_h_idx;
    logic [TAG_BITS-1:0] w_h_tag;
    logic                w_h_hit;
    logic [WIDTH-1:0]    w_merged;

    // Store formatting for the incoming access.
    logic [3:0]          w_st_wstrb;
    logic [WIDTH-1:0]    w_st_wdata;

    // Control strobes from the FSM.
    logic                w_cap;
    logic                w_fill_we;
    logic                w_merge_we;

    assign w_idx     = AddrM[IDX_BITS+1:2];
    assign w_tag     = AddrM[WIDTH-1:IDX_BITS+2];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line    = r_data[w_idx];
    assign w_shifted = w_line >> {AddrM[1:0], 3'b000};
    assign w_byte    = w_shifted[7:0];

    assign w_h_idx   = r_waddr[IDX_BITS-1:0];
    assign w_h_tag   = r_waddr[WIDTH-3:IDX_BITS];
    assign w_h_hit   = r_valid[w_h_idx] && (r_tag[w_h_idx] == w_h_tag);

    // Byte stores put the byte on every lane; the strobe selects the lane.
    assign w_st_wstrb = a_typeM ? (4'b0001 << AddrM[1:0]) : 4'hF;
    assign w_st_wdata = a_typeM ? {4{WriteDataM[7:0]}} : WriteDataM;

    assign o_dbg_state = r_state;

    // Merge the strobed store bytes into the held line (write-through update).
    always_comb begin
        w_merged = r_data[w_h_idx];
        for (int b = 0; b < 4; b++) begin
            if (r_wstrb[b]) begin
                w_merged[8*b +: 8] = r_wdata[8*b +: 8];
            end
        end
    end

    // Next-state and output decode; every output defaults to idle values.
    always_comb begin
        w_next     = r_state;
        StallM     = 1'b0;
        ReadDataM  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = 4'h0;
        w_cap      = 1'b0;
        w_fill_we  = 1'b0;
        w_merge_we = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MemWriteM) begin
                    // Stores always go to memory, also when MemReadM is set.
                    StallM = 1'b1;
                    w_cap  = 1'b1;
                    w_next = S_WRITE;
                end else if (MemReadM) begin
                    if (w_hit) begin
                        ReadDataM = a_typeM ? {{(WIDTH-8){1'b0}}, w_byte} : w_line;
                    end else begin
                        StallM = 1'b1;
                        w_cap  = 1'b1;
                        w_next = S_FILL;
                    end
                end
            end
            S_FILL: begin
                StallM   = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {r_waddr, 2'b00};
                if (mem_ack) begin
                    w_fill_we = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_WRITE: begin
                StallM    = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_waddr, 2'b00};
                mem_wdata = r_wdata;
                mem_wstrb = r_wstrb;
                if (mem_ack) begin
                    w_merge_we = w_h_hit;
                    w_next     = S_WDONE;
                end
            end
            S_WDONE: begin
                // One unstalled cycle lets the pipeline retire the store.
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register; reset forces IDLE so mem_req drops immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the missing/storing access for the memory transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waddr <= '0;
            r_wdata <= '0;
            r_wstrb <= 4'h0;
        end else if (w_cap) begin
            r_waddr <= AddrM[WIDTH-1:2];
            r_wdata <= w_st_wdata;
            r_wstrb <= w_st_wstrb;
        end
    end

    // Valid bits: cleared by reset, set when a fill completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_fill_we) begin
            r_valid[w_h_idx] <= 1'b1;
        end
    end

    // Tag/data update on fill completion or on a store that hits.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_tag[w_h_idx]  <= w_h_tag;
            r_data[w_h_idx] <= mem_rdata;
        end else if (w_merge_we) begin
            r_data[w_h_idx] <= w_merged;
        end
    end

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Testbench for dcache_mem_stage: directed scenarios followed by random
// loads/stores against a reference model of the cache and backing memory.
module tb_dcache_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM, a_typeM;
    logic [31:0] AddrM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: which word address each line holds, and its contents.
    bit          m_valid [8];
    logic [31:0] m_addr  [8];
    logic [31:0] m_data  [8];
    // Backing memory contents, word-addressed; unseen words get random data.
    logic [31:0] bmem [logic [31:0]];

    dcache_mem_stage #(.WIDTH(32), .IDX_BITS(3)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .a_typeM(a_typeM),
        .AddrM(AddrM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        if (!bmem.exists(wa)) bmem[wa] = $urandom;
        return bmem[wa];
    endfunction

    function automatic logic [31:0] load_view(input logic [31:0] word, input logic [31:0] addr, input bit byt);
        if (byt) return (word >> (8 * addr[1:0])) & 32'hFF;
        return word;
    endfunction

    function automatic void model_invalidate();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endfunction

    // One pipeline access (or an idle cycle when rd=wr=0). lat is the number of
    // request cycles before the backing memory acks (ack in the lat-th one).
    task automatic do_access(input bit rd, input bit wr, input bit byt,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int lat, input bit stray_ack);
        logic [31:0] wa, fdat, wdat, merged;
        logic [3:0]  strb;
        int          li, stalls;
        bit          hit;
        wa  = addr & 32'hFFFF_FFFC;
        li  = (addr >> 2) % 8;
        hit = rd && !wr && m_valid[li] && (m_addr[li] == wa);

        @(posedge clk); #1;
        mem_ack    = 1'b0;
        MemReadM   = rd;
        MemWriteM  = wr;
        a_typeM    = byt;
        AddrM      = addr;
        WriteDataM = wd;
        @(negedge clk);

        if (!rd && !wr) begin
            check("idle_stall", StallM, 0);
            check("idle_rdata", ReadDataM, 0);
            check("idle_req", mem_req, 0);
            if (stray_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
        end else if (hit) begin
            check("hit_stall", StallM, 0);
            check("hit_rdata", ReadDataM, load_view(m_data[li], addr, byt));
            check("hit_req", mem_req, 0);
        end else begin
            stalls = StallM ? 1 : 0;
            check("miss_first_req", mem_req, 0);
            check("miss_first_rdata", ReadDataM, 0);
            strb = wr ? (byt ? (4'b0001 << addr[1:0]) : 4'hF) : 4'h0;
            wdat = byt ? {4{wd[7:0]}} : wd;
            fdat = mem_word(wa);
            for (int n = 1; n <= lat; n++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (StallM) stalls++;
                check("req", mem_req, 1);
                check("req_we", mem_we, wr);
                check("req_addr", mem_addr, wa);
                check("req_rdata0", ReadDataM, 0);
                if (wr) begin
                    check("req_wstrb", mem_wstrb, strb);
                    check("req_wdata", mem_wdata, wdat);
                end
                if (n == lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = wr ? $urandom : fdat;
                end
            end
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            @(negedge clk);
            check("stall_cycles", stalls, lat + 1);
            check("after_stall", StallM, 0);
            check("after_req", mem_req, 0);
            if (wr) begin
                check("wdone_rdata", ReadDataM, 0);
                merged = fdat;
                for (int b = 0; b < 4; b++)
                    if (strb[b]) merged[8*b +: 8] = wdat[8*b +: 8];
                bmem[wa] = merged;
                if (m_valid[li] && m_addr[li] == wa) m_data[li] = merged;
            end else begin
                check("fill_rdata", ReadDataM, load_view(fdat, addr, byt));
                m_valid[li] = 1'b1;
                m_addr[li]  = wa;
                m_data[li]  = fdat;
            end
        end
    endtask

    initial begin
        bit rd, wr;
        int op;
        logic [31:0] ra;

        rst = 1'b1;
        MemReadM = 0; MemWriteM = 0; a_typeM = 0;
        AddrM = 0; WriteDataM = 0; mem_ack = 0; mem_rdata = 0;
        model_invalidate();
        #3;
        check("rst_stall", StallM, 0);
        check("rst_rdata", ReadDataM, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst_state", o_dbg_state, 0);
        #9 rst = 1'b0;

        // Cold word load with ack latency 3, then an immediate reload hit.
        bmem[32'h100] = 32'hDEADBEEF;
        do_access(1, 0, 0, 32'h100, 0, 3, 0);
        check("cold_load_value", ReadDataM, 32'hDEADBEEF);
        do_access(1, 0, 0, 32'h100, 0, 1, 0);
        // Byte load of the top byte.
        do_access(1, 0, 1, 32'h103, 0, 1, 0);
        check("byte_load_value", ReadDataM, 32'h0000_00DE);
        // Byte store into a resident line, then reload the merged word.
        do_access(0, 1, 1, 32'h101, 32'h0000_0055, 2, 0);
        do_access(1, 0, 0, 32'h100, 0, 1, 0);
        check("merged_value", ReadDataM, 32'hDEAD55EF);
        // Store miss does not allocate: the following load must fill.
        do_access(0, 1, 0, 32'h200, 32'h1234_5678, 1, 0);
        do_access(1, 0, 0, 32'h200, 0, 2, 0);
        // Conflict on index 0 evicts 0x100.
        do_access(1, 0, 0, 32'h120, 0, 1, 0);
        do_access(1, 0, 0, 32'h100, 0, 4, 0);
        // Read and write together behave as a store.
        do_access(1, 1, 0, 32'h104, 32'hCAFE_F00D, 1, 0);
        do_access(1, 0, 0, 32'h104, 0, 1, 0);
        // Idle cycle with a stray ack.
        do_access(0, 0, 0, 32'h100, 0, 1, 1);
        do_access(1, 0, 0, 32'h100, 0, 1, 0);

        // Reset in the middle of a fill, then a late ack.
        @(posedge clk); #1;
        mem_ack = 0; MemReadM = 1; MemWriteM = 0; a_typeM = 0; AddrM = 32'h300;
        @(negedge clk);
        check("rfill_stall", StallM, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rfill_req", mem_req, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        MemReadM = 0;
        #1;
        check("rfill_req_drop", mem_req, 0);
        check("rfill_state", o_dbg_state, 0);
        check("rfill_stall_drop", StallM, 0);
        model_invalidate();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        check("late_ack_req", mem_req, 0);
        check("late_ack_stall", StallM, 0);
        do_access(1, 0, 0, 32'h100, 0, 2, 0);
        do_access(1, 0, 0, 32'h104, 0, 1, 0);

        // Random traffic over a small address set to force hits and conflicts.
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            ra = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            rd = (op <= 3) || (op == 7);
            wr = (op >= 4) && (op <= 7);
            do_access(rd, wr, 1'($urandom_range(0, 1)), ra, $urandom,
                      $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        MemReadM = 0; MemWriteM = 0; mem_ack = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_mem_stage.md
Name: dcache_mem_stage

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits in the memory stage, between the execute/memory pipeline register outputs (ALU result as address, store data, access type) and a variable-latency backing data memory.
- Returns load data to the writeback path and raises a stall to the hazard unit while it is waiting on the backing memory.
- Line size is one 32-bit word.

Parameters:
WIDTH, 32, data and address width
IDX_BITS, 3, index width; 2**IDX_BITS lines (default 8)

Ports:
clk  in  1  CPU clock
rst  in  1  reset, asynchronous, active-high
MemReadM  in  1  load in memory stage
MemWriteM  in  1  store in memory stage
a_typeM  in  1  access size: 1 = byte, 0 = word
AddrM  in  WIDTH  byte address (ALU result)
WriteDataM  in  WIDTH  store data
ReadDataM  out  WIDTH  load data
StallM  out  1  freeze F/D/E/M pipeline registers
mem_req  out  1  backing-memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  WIDTH  word-aligned address (bits[1:0] = 0)
mem_wdata  out  WIDTH  write data
mem_wstrb  out  4  byte enables
mem_ack  in  1  one-cycle completion pulse
mem_rdata  in  WIDTH  read data, valid with mem_ack

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset state: all valid bits 0, state IDLE. mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb and StallM are 0; ReadDataM is 0.
- Address split: index = AddrM[IDX_BITS+1:2]; tag = AddrM[WIDTH-1:IDX_BITS+2]. Hit = valid[index] && tag match.
- FSM states: IDLE, FILL, WRITE, WDONE.
- IDLE, load hit:
  - ReadDataM is valid combinationally in the same cycle; StallM = 0.
  - Word access: line data.
  - Byte access: byte AddrM[1:0] of the line, zero-extended.
- IDLE, load miss:
  - StallM = 1 combinationally.
  - Next state FILL; latch the aligned address.
- FILL:
  - mem_req = 1, mem_we = 0, mem_addr held; StallM = 1.
  - On mem_ack: write tag, mem_rdata and valid into the line; go to IDLE.
  - The held load then hits on the following cycle with StallM = 0.
  - Miss penalty = ack latency + 1 stall cycle beyond the request cycles.
- IDLE, store (hit or miss):
  - StallM = 1 combinationally.
  - Next state WRITE; latch address, data and strobe.
  - Word store: wstrb = 4'hF, wdata = WriteDataM.
  - Byte store: wstrb = 1 << AddrM[1:0], wdata = WriteDataM[7:0] replicated ×4.
- WRITE:
  - mem_req = 1, mem_we = 1; StallM = 1.
  - On mem_ack: if the line hits, merge the strobed bytes into the line; a miss does not allocate. Go to WDONE.
- WDONE:
  - StallM = 0 for exactly one cycle so the pipeline advances past the store.
  - The held store is not reissued; next state IDLE.
- MemReadM and MemWriteM both 1: treated as a store.
- Neither asserted: StallM = 0, ReadDataM = 0, no memory activity.
- ReadDataM is 0 whenever the cycle is not a load hit.
- mem_ack outside FILL/WRITE is ignored.
- mem_req stays asserted and the other mem_* signals stay stable until mem_ack.
- rst mid-transaction: immediate return to IDLE, mem_req drops asynchronously, all lines invalidated. A late ack is ignored.
- AddrM[1:0] is ignored for word accesses. Misalignment is not checked.

Test Plan:
- Cold load word from 0x100, ack after 3 cycles with 0xDEADBEEF -> StallM high for 4 cycles; ReadDataM = 0xDEADBEEF with StallM = 0; an immediate reload of 0x100 hits with no stall and no mem_req.
- Byte load from 0x103 after the line above is filled -> ReadDataM = 0x000000DE in the same cycle, StallM = 0.
- Byte store of 0x55 to 0x101 (hit) -> mem_wstrb = 4'b0010, mem_wdata = 0x55555555; after ack, one WDONE cycle; a load from 0x100 returns 0xDEAD55EF.
- Store to 0x200 (miss) -> mem write issued; a subsequent load of 0x200 misses and triggers FILL (no allocate).
- Conflict: fill 0x100, then load 0x120 (same index with IDX_BITS = 3) -> miss, line replaced; reload 0x100 misses again.
- Assert rst during FILL before ack, then pulse mem_ack -> mem_req 0 immediately; state IDLE; all prior hits now miss; the stray ack changes nothing.
